genpc_pred: RTL and testbench



---
 rtl/genpc_pkg.sv | 36 +++
 rtl/genpc_ras.sv | 58 +++++
 rtl/genpc_pred.sv | 147 ++++++++++++++
 tb/tb_genpc_pred.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genpc_pkg.sv
// Shared types and helpers for the predicting next-PC generator.
package genpc_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_cnt_e;

   // Link registers recognised by the mini-decoder for call/return hints
   localparam logic [4:0] REG_X1 = 5'd1;
   localparam logic [4:0] REG_X5 = 5'd5;

   function automatic int off_w(input int fetch_bytes);
      return $clog2(fetch_bytes);
   endfunction

   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic bht_cnt_e sat_upd(input bht_cnt_e c,
                                        input logic     up);
      bht_cnt_e r;
      r = c;
      unique case (c)
         SNT:     r = up ? WNT : SNT;
         WNT:     r = up ? WT  : SNT;
         WT:      r = up ? ST  : WNT;
         default: r = up ? ST  : WT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/genpc_ras.sv
// Circular return address stack; a push when full drops the oldest entry.
module genpc_ras
   import genpc_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            cpurst,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] stk [DEPTH];
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_inc;
   logic [PW-1:0]   ptr_dec;
   logic [CW-1:0]   cnt;
   logic            do_pop;

   assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);
   assign top     = stk[ptr_dec];
   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (cpurst) begin
         ptr <= '0;
         cnt <= '0;
      end else begin
         unique case ({push, do_pop})
            2'b10: begin
               stk[ptr] <= push_data;
               ptr      <= ptr_inc;
               if (!full)
                  cnt <= cnt + CW'(1);
            end
            2'b01: begin
               ptr <= ptr_dec;
               cnt <= cnt - CW'(1);
            end
            // call-through-return: replace top in place
            2'b11: stk[ptr_dec] <= push_data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/genpc_pred.sv
// Fetch next-PC generator with 2-bit BHT and return address stack.
module genpc_pred
   import genpc_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int FETCH_BYTES = 8,
   parameter int BHT_ENTRIES = 16,
   parameter int RAS_DEPTH   = 4
) (
   input  logic                                clk,
   input  logic                                cpurst,
   input  logic [XLEN-1:0]                     boot_addr,
   input  logic                                fet_stall,
   input  logic                                fetch_misalign,
   input  logic                                jalr_dep,
   input  logic                                isrv16,
   input  logic                                isjal,
   input  logic                                isjalr,
   input  logic                                isbxx,
   input  logic                                is_call,
   input  logic                                is_ret,
   input  logic [XLEN-1:0]                     jaloffset,
   input  logic [XLEN-1:0]                     bxxoffset,
   input  logic [XLEN-1:0]                     jalr_target,
   input  logic                                trap_redirect,
   input  logic [XLEN-1:0]                     trap_target,
   input  logic                                branch_predict_err,
   input  logic [XLEN-1:0]                     de2fe_branch_target,
   input  logic                                upd_valid,
   input  logic [XLEN-1:0]                     upd_pc,
   input  logic                                upd_taken,
   output logic [XLEN-1:0]                     pc,
   output logic [XLEN-off_w(FETCH_BYTES)-1:0]  isram_adr,
   output logic                                isram_cs,
   output logic                                isram_cs_ff,
   output logic                                cross_bd_ff,
   output logic                                predict_taken,
   output logic                                ras_hit,
   output logic                                holdpc,
   output logic                                jb_ff
);

   localparam int OFF = off_w(FETCH_BYTES);
   localparam int IDX = idx_w(BHT_ENTRIES);
   localparam int AW  = XLEN - OFF;

   logic [XLEN-1:0] nxtpc;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] ras_top;
   logic [AW-1:0]   isram_adr_ff;
   logic [IDX-1:0]  rd_idx;
   logic [IDX-1:0]  wr_idx;
   logic            redirect;
   logic            cross_bd;
   logic            suppress;
   logic            ras_push;
   logic            ras_pop;
   logic            ras_empty;
   logic            ras_full;
   logic            unused_bits;
   bht_cnt_e        bht [BHT_ENTRIES];

   assign seq_pc   = pc + (isrv16 ? XLEN'(2) : XLEN'(4));
   assign redirect = trap_redirect | branch_predict_err;
   assign rd_idx   = pc[IDX:1];
   assign wr_idx   = upd_pc[IDX:1];

   assign predict_taken = bht[rd_idx][1];
   assign ras_hit  = isjalr & is_ret & ~ras_empty & ~cross_bd_ff;
   assign holdpc   = fet_stall | fetch_misalign | (jalr_dep & ~ras_hit);

   always_comb begin
      nxtpc = seq_pc;
      if (trap_redirect)
         nxtpc = trap_target;
      else if (branch_predict_err)
         nxtpc = de2fe_branch_target;
      else if (holdpc | cross_bd_ff)
         nxtpc = pc;
      else if (isjal)
         nxtpc = pc + jaloffset;
      else if (ras_hit)
         nxtpc = ras_top;
      else if (isjalr)
         nxtpc = jalr_target;
      else if (isbxx & predict_taken)
         nxtpc = pc + bxxoffset;
   end

   // Instruction starting on the line's last halfword spills into the next line
   assign cross_bd = &nxtpc[OFF-1:1];

   always_comb begin
      isram_adr = nxtpc[XLEN-1:OFF];
      if (cpurst)
         isram_adr = boot_addr[XLEN-1:OFF];
      else if (cross_bd_ff & ~redirect)
         isram_adr = pc[XLEN-1:OFF] + AW'(1);
   end

   assign isram_cs = cpurst | (isram_adr != isram_adr_ff) | cross_bd;

   assign suppress = holdpc | cross_bd_ff | redirect;
   assign ras_push = (isjal | isjalr) & is_call & ~suppress;
   assign ras_pop  = ras_hit & ~suppress;

   genpc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .cpurst    (cpurst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   always_ff @(posedge clk) begin
      isram_adr_ff <= isram_adr;
      if (cpurst) begin
         pc          <= '0;
         cross_bd_ff <= 1'b0;
         jb_ff       <= 1'b0;
         isram_cs_ff <= 1'b0;
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= WNT;
      end else begin
         pc          <= nxtpc;
         isram_cs_ff <= isram_cs;
         jb_ff       <= isjal | isjalr | (isbxx & predict_taken) |
                        branch_predict_err | trap_redirect;
         if (cross_bd_ff & ~redirect)
            cross_bd_ff <= 1'b0;
         else
            cross_bd_ff <= cross_bd;
         if (upd_valid)
            bht[wr_idx] <= sat_upd(bht[wr_idx], upd_taken);
      end
   end

   assign unused_bits = ^{boot_addr[OFF-1:0], upd_pc[XLEN-1:IDX+1],
                          upd_pc[0], ras_full};

endmodule

// File: tb/tb_genpc_pred.sv
// Directed bench for genpc_pred with a per-cycle reference model.
module tb_genpc_pred;

   logic        clk = 1'b0;
   logic        cpurst;
   logic [31:0] boot_addr;
   logic        fet_stall, fetch_misalign, jalr_dep, isrv16;
   logic        isjal, isjalr, isbxx, is_call, is_ret;
   logic [31:0] jaloffset, bxxoffset, jalr_target;
   logic        trap_redirect, branch_predict_err;
   logic [31:0] trap_target, de2fe_branch_target;
   logic        upd_valid, upd_taken;
   logic [31:0] upd_pc;
   logic [31:0] pc;
   logic [28:0] isram_adr;
   logic        isram_cs, isram_cs_ff, cross_bd_ff;
   logic        predict_taken, ras_hit, holdpc, jb_ff;

   genpc_pred dut (
      .clk                 (clk),
      .cpurst              (cpurst),
      .boot_addr           (boot_addr),
      .fet_stall           (fet_stall),
      .fetch_misalign      (fetch_misalign),
      .jalr_dep            (jalr_dep),
      .isrv16              (isrv16),
      .isjal               (isjal),
      .isjalr              (isjalr),
      .isbxx               (isbxx),
      .is_call             (is_call),
      .is_ret              (is_ret),
      .jaloffset           (jaloffset),
      .bxxoffset           (bxxoffset),
      .jalr_target         (jalr_target),
      .trap_redirect       (trap_redirect),
      .trap_target         (trap_target),
      .branch_predict_err  (branch_predict_err),
      .de2fe_branch_target (de2fe_branch_target),
      .upd_valid           (upd_valid),
      .upd_pc              (upd_pc),
      .upd_taken           (upd_taken),
      .pc                  (pc),
      .isram_adr           (isram_adr),
      .isram_cs            (isram_cs),
      .isram_cs_ff         (isram_cs_ff),
      .cross_bd_ff         (cross_bd_ff),
      .predict_taken       (predict_taken),
      .ras_hit             (ras_hit),
      .holdpc              (holdpc),
      .jb_ff               (jb_ff)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference model state
   bit          m_valid = 0;
   logic [31:0] m_pc;
   bit          m_cross, m_jb, m_csff;
   logic [28:0] m_adrff;
   int          m_bht [16];
   logic [31:0] m_ras [$];
   logic [31:0] n_pc;
   bit          n_cross, n_jb, n_cs;
   logic [28:0] n_adr;
   int          n_bht [16];
   logic [31:0] n_ras [$];
   logic [31:0] e_nx, e_step;
   logic [28:0] e_adr;
   bit          e_pt, e_rh, e_hold, e_cb, e_redir, e_cs, e_sup, e_push, e_pop;
   int          e_i;

   always @(negedge clk) begin
      if (cpurst) begin
         chk("adr_in_reset", 32'(isram_adr), 32'(boot_addr >> 3));
         chk("cs_in_reset", 32'(isram_cs), 1);
      end else if (m_valid) begin
         e_step  = isrv16 ? 2 : 4;
         e_pt    = m_bht[(m_pc >> 1) % 16] >= 2;
         e_rh    = isjalr && is_ret && m_ras.size() > 0 && !m_cross;
         e_hold  = fet_stall || fetch_misalign || (jalr_dep && !e_rh);
         e_redir = trap_redirect || branch_predict_err;
         if (trap_redirect)                e_nx = trap_target;
         else if (branch_predict_err)      e_nx = de2fe_branch_target;
         else if (e_hold || m_cross)       e_nx = m_pc;
         else if (isjal)                   e_nx = m_pc + jaloffset;
         else if (e_rh)                    e_nx = m_ras[$];
         else if (isjalr)                  e_nx = jalr_target;
         else if (isbxx && e_pt)           e_nx = m_pc + bxxoffset;
         else                              e_nx = m_pc + e_step;
         e_cb  = (e_nx % 8) == 6;
         e_adr = (m_cross && !e_redir) ? 29'((m_pc >> 3) + 1)
                                       : 29'(e_nx >> 3);
         e_cs  = (e_adr != m_adrff) || e_cb;
         chk("pc", pc, m_pc);
         chk("isram_adr", 32'(isram_adr), 32'(e_adr));
         chk("isram_cs", 32'(isram_cs), 32'(e_cs));
         chk("isram_cs_ff", 32'(isram_cs_ff), 32'(m_csff));
         chk("cross_bd_ff", 32'(cross_bd_ff), 32'(m_cross));
         chk("predict_taken", 32'(predict_taken), 32'(e_pt));
         chk("ras_hit", 32'(ras_hit), 32'(e_rh));
         chk("holdpc", 32'(holdpc), 32'(e_hold));
         chk("jb_ff", 32'(jb_ff), 32'(m_jb));
         n_pc    = e_nx;
         n_cross = (m_cross && !e_redir) ? 0 : e_cb;
         n_jb    = isjal || isjalr || (isbxx && e_pt) || e_redir;
         n_cs    = e_cs;
         n_adr   = e_adr;
         n_bht   = m_bht;
         if (upd_valid) begin
            e_i = (upd_pc >> 1) % 16;
            if (upd_taken && n_bht[e_i] < 3)       n_bht[e_i]++;
            else if (!upd_taken && n_bht[e_i] > 0) n_bht[e_i]--;
         end
         n_ras  = m_ras;
         e_sup  = e_hold || m_cross || e_redir;
         e_push = (isjal || isjalr) && is_call && !e_sup;
         e_pop  = e_rh && !e_sup;
         if (e_push && e_pop)
            n_ras[n_ras.size() - 1] = m_pc + e_step;
         else if (e_push) begin
            n_ras.push_back(m_pc + e_step);
            if (n_ras.size() > 4) void'(n_ras.pop_front());
         end else if (e_pop)
            void'(n_ras.pop_back());
      end
   end

   always @(posedge clk) begin
      if (cpurst) begin
         m_pc = 0; m_cross = 0; m_jb = 0; m_csff = 0;
         m_adrff = boot_addr[31:3];
         m_ras.delete();
         foreach (m_bht[i]) m_bht[i] = 1;
         m_valid = 1;
      end else if (m_valid) begin
         m_pc = n_pc; m_cross = n_cross; m_jb = n_jb; m_csff = n_cs;
         m_adrff = n_adr; m_bht = n_bht; m_ras = n_ras;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fet_stall = 0; fetch_misalign = 0; jalr_dep = 0; isrv16 = 0;
      isjal = 0; isjalr = 0; isbxx = 0; is_call = 0; is_ret = 0;
      trap_redirect = 0; branch_predict_err = 0; upd_valid = 0;
      upd_taken = 0;
   endtask

   task automatic jump(input logic [31:0] t);
      trap_redirect = 1; trap_target = t;
      tick();
      trap_redirect = 0;
   endtask

   logic [31:0] rets [4];

   initial begin
      idle();
      jaloffset = 0; bxxoffset = 0; jalr_target = 0; upd_pc = 0;
      trap_target = 0; de2fe_branch_target = 0;
      cpurst = 1; boot_addr = 32'h1000;
      #2;
      chk("lit_rst_adr", 32'(isram_adr), 32'h200);
      chk("lit_rst_cs", 32'(isram_cs), 1);
      tick(); tick();
      cpurst = 0;
      chk("lit_pc_rst", pc, 0);
      tick(); chk("lit_pc4", pc, 32'h4);
      tick(); chk("lit_pc8", pc, 32'h8);

      // compressed instruction straddling a line
      jump(32'h4);
      isrv16 = 1;
      tick();
      #1;
      chk("lit_cross_set", 32'(cross_bd_ff), 1);
      chk("lit_cross_adr", 32'(isram_adr), 32'h1);
      chk("lit_cross_pc", pc, 32'h6);
      tick();
      chk("lit_cross_hold", pc, 32'h6);
      chk("lit_cross_clr", 32'(cross_bd_ff), 0);
      tick(); chk("lit_cross_next", pc, 32'h8);
      isrv16 = 0;

      fet_stall = 1; #1;
      chk("lit_holdpc", 32'(holdpc), 1);
      tick(); chk("lit_stall", pc, 32'h8);
      fet_stall = 0; fetch_misalign = 1;
      tick(); chk("lit_misalign", pc, 32'h8);
      fetch_misalign = 0;

      // BHT training at 0x20
      jump(32'h20);
      isbxx = 1; bxxoffset = 32'h40;
      upd_valid = 1; upd_pc = 32'h20; upd_taken = 1;
      #1; chk("lit_bht_wnt", 32'(predict_taken), 0);
      tick(); chk("lit_bht_fall", pc, 32'h24);
      isbxx = 0;
      tick();
      upd_valid = 0;
      jump(32'h20);
      isbxx = 1; #1;
      chk("lit_bht_st", 32'(predict_taken), 1);
      tick(); chk("lit_bht_taken", pc, 32'h60);
      isbxx = 0;
      upd_valid = 1; upd_taken = 0;
      repeat (4) tick();
      upd_valid = 0;
      jump(32'h20);
      isbxx = 1; #1;
      chk("lit_bht_snt", 32'(predict_taken), 0);
      tick(); isbxx = 0;
      upd_valid = 1; upd_taken = 1;
      tick(); upd_valid = 0;
      jump(32'h20);
      isbxx = 1; #1;
      chk("lit_bht_sat", 32'(predict_taken), 0);
      tick(); isbxx = 0;

      // call then predicted return
      jump(32'h100);
      isjal = 1; is_call = 1; jaloffset = 32'h200;
      tick(); chk("lit_call", pc, 32'h300);
      isjal = 0; is_call = 0;
      isjalr = 1; is_ret = 1; jalr_dep = 1; jalr_target = 32'hdead0;
      #1;
      chk("lit_ret_hit", 32'(ras_hit), 1);
      chk("lit_ret_nohold", 32'(holdpc), 0);
      tick(); chk("lit_ret_pc", pc, 32'h104);
      idle();

      // five nested calls against a four-deep stack
      isjal = 1; is_call = 1; jaloffset = 32'h100;
      repeat (5) tick();
      idle();
      rets = '{32'h508, 32'h408, 32'h308, 32'h208};
      isjalr = 1; is_ret = 1; jalr_dep = 1; jalr_target = 32'h9000;
      for (int k = 0; k < 4; k++) begin
         #1; chk("lit_nest_hit", 32'(ras_hit), 1);
         tick(); chk("lit_nest_pc", pc, rets[k]);
      end
      #1;
      chk("lit_nest_miss", 32'(ras_hit), 0);
      chk("lit_nest_wait", 32'(holdpc), 1);
      tick(); chk("lit_nest_held", pc, 32'h208);
      jalr_dep = 0;
      tick(); chk("lit_nest_reg", pc, 32'h9000);
      idle();

      // jalr that is both call and return
      jump(32'h700);
      isjal = 1; is_call = 1; jaloffset = 32'h100;
      tick(); isjal = 0;
      isjalr = 1; is_ret = 1;
      tick(); chk("lit_swap_pc", pc, 32'h704);
      is_call = 0;
      tick(); chk("lit_swap_ret", pc, 32'h804);
      #1; chk("lit_swap_empty", 32'(ras_hit), 0);
      tick(); idle();

      // trap and mispredict together while a cross fetch is pending
      jump(32'h6);
      trap_redirect = 1; trap_target = 32'h40;
      branch_predict_err = 1; de2fe_branch_target = 32'h80;
      #1; chk("lit_redir_adr", 32'(isram_adr), 32'h8);
      tick();
      chk("lit_redir_pc", pc, 32'h40);
      chk("lit_redir_clr", 32'(cross_bd_ff), 0);
      idle();
      jump(32'h16);
      trap_redirect = 1; trap_target = 32'h2e;
      branch_predict_err = 1;
      tick();
      chk("lit_redir_pc2", pc, 32'h2e);
      chk("lit_redir_keep", 32'(cross_bd_ff), 1);
      idle();
      tick(); tick();

      // reset with a cross fetch in flight
      jump(32'h6);
      cpurst = 1; boot_addr = 32'h2000; #1;
      chk("lit_rst2_adr", 32'(isram_adr), 32'h400);
      tick(); cpurst = 0;
      chk("lit_rst2_pc", pc, 0);
      chk("lit_rst2_cross", 32'(cross_bd_ff), 0);
      chk("lit_rst2_jb", 32'(jb_ff), 0);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
